// File: rtl/yarp_lsu_pkg.sv
// Shared types for the YARP load/store unit.
//   lsu_state_e       : LSU bus-transaction state
//   mem_access_size_t : access size encoding driven by yarp_control (2'b10 is illegal)
package yarp_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_t;

    localparam int unsigned XLEN = 32;

endpackage

// File: rtl/yarp_lsu_if.sv
// Data-memory bus between the LSU (master) and data memory (slave).
//   mem_req_o    : bus request            (master -> slave)
//   mem_addr_o   : word-aligned address   (master -> slave)
//   mem_wr_o     : write strobe           (master -> slave)
//   mem_be_o     : byte enables           (master -> slave)
//   mem_wdata_o  : lane-replicated data   (master -> slave)
//   mem_gnt_i    : request granted        (slave -> master)
//   mem_rvalid_i : read data / write ack  (slave -> master)
//   mem_rdata_i  : read data              (slave -> master)
interface yarp_lsu_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_wr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_wr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/yarp_lsu_align.sv
// Combinational byte-lane steering for the LSU.
//   Forward path (store/request side):
//     size_i, addr_lo_i, wdata_i -> be_o, wdata_o, misalign_o
//   Reverse path (load side):
//     rd_size_i, rd_addr_lo_i, rd_zext_i, rdata_i -> rdata_o (extended result)
module yarp_lsu_align
    import yarp_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,

    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_addr_lo_i,
    input  logic        rd_zext_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o       = '0;
        wdata_o    = '0;
        misalign_o = 1'b0;
        case (size_i)
            BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            HALF_WORD: begin
                be_o       = 4'b0011 << addr_lo_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            WORD: begin
                be_o       = '1;
                wdata_o    = wdata_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: misalign_o = 1'b1;   // 2'b10 is not a legal size
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rdata_i >> {rd_addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = '0;
        case (rd_size_i)
            BYTE:      rdata_o = {{24{~rd_zext_i & shifted[7]}}, shifted[7:0]};
            HALF_WORD: rdata_o = {{16{~rd_zext_i & shifted[15]}}, shifted[15:0]};
            WORD:      rdata_o = shifted;
            default:   rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/yarp_lsu.sv
// YARP load/store unit (execute stage, downstream of yarp_control).
// Runs one req/gnt + rvalid transaction per memory op and stalls the core
// until it completes, is rejected as misaligned, or times out.
//   clk, reset          : core clock, asynchronous active-high reset
//   data_req_i .. data_wdata_i : op request from control/ALU, sampled in IDLE only
//   lsu_stall_o         : hold PC/pipeline
//   lsu_rd_valid_o      : one-cycle completion pulse
//   lsu_rd_data_o       : extended load result (0 for stores/aborts)
//   lsu_misalign_o      : pulse with rd_valid, misaligned address or illegal size
//   lsu_timeout_o       : pulse with rd_valid, bus did not respond in time
//   mem                 : data-memory bus (master side)
module yarp_lsu
    import yarp_lsu_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset,

    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_byte_i,
    input  logic        zero_extnd_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,

    output logic        lsu_stall_o,
    output logic        lsu_rd_valid_o,
    output logic [31:0] lsu_rd_data_o,
    output logic        lsu_misalign_o,
    output logic        lsu_timeout_o,

    yarp_lsu_if.master  mem
);

    localparam int unsigned      CNT_W    = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic             wr_q, wr_d;
    logic             zext_q, zext_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             misalign_q, misalign_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic [3:0]       fwd_be;
    logic [31:0]      fwd_wdata;
    logic             fwd_misalign;
    logic [31:0]      ld_data;

    // Forward path runs on the live inputs; its results are captured in IDLE
    // so the bus fields stay stable no matter what the inputs do later.
    yarp_lsu_align u_align (
        .size_i       (data_byte_i),
        .addr_lo_i    (data_addr_i[1:0]),
        .wdata_i      (data_wdata_i),
        .be_o         (fwd_be),
        .wdata_o      (fwd_wdata),
        .misalign_o   (fwd_misalign),
        .rd_size_i    (size_q),
        .rd_addr_lo_i (addr_q[1:0]),
        .rd_zext_i    (zext_q),
        .rdata_i      (mem.mem_rdata_i),
        .rdata_o      (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            wr_q       <= 1'b0;
            zext_q     <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wr_q       <= wr_d;
            zext_q     <= zext_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wr_d       = wr_q;
        zext_d     = zext_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (data_req_i) begin
                    addr_d     = data_addr_i;
                    size_d     = data_byte_i;
                    wr_d       = data_wr_i;
                    zext_d     = zero_extnd_i;
                    be_d       = fwd_be;
                    wdata_d    = fwd_wdata;
                    misalign_d = fwd_misalign;
                    timeout_d  = 1'b0;
                    rd_data_d  = '0;
                    state_d    = fwd_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Budget exhausted wins over a same-cycle grant.
                if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (mem.mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the last budgeted cycle still completes normally.
                if (mem.mem_rvalid_i) begin
                    rd_data_d = wr_q ? '0 : ld_data;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic in_req;
    logic in_done;

    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    assign lsu_stall_o    = ~reset & (((state_q == IDLE) & data_req_i) | in_req | (state_q == WAIT));
    assign lsu_rd_valid_o = in_done;
    assign lsu_misalign_o = in_done & misalign_q;
    assign lsu_timeout_o  = in_done & timeout_q;
    assign lsu_rd_data_o  = in_done ? rd_data_q : '0;

    assign mem.mem_req_o   = in_req;
    assign mem.mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem.mem_wr_o    = in_req & wr_q;
    assign mem.mem_be_o    = in_req ? be_q : '0;
    assign mem.mem_wdata_o = in_req ? wdata_q : '0;

endmodule

// File: tb/tb_yarp_lsu.sv
// Self-checking bench for yarp_lsu: directed cases with literal expectations,
// then randomized ops whose expectations come from arithmetic reference functions.
module tb_yarp_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_byte = 2'b00;
    logic        zero_extnd = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        lsu_stall, lsu_rd_valid, lsu_misalign, lsu_timeout;
    logic [31:0] lsu_rd_data;

    yarp_lsu_if bus ();

    yarp_lsu #(.RSP_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_req_i     (data_req),
        .data_wr_i      (data_wr),
        .data_byte_i    (data_byte),
        .zero_extnd_i   (zero_extnd),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .lsu_stall_o    (lsu_stall),
        .lsu_rd_valid_o (lsu_rd_valid),
        .lsu_rd_data_o  (lsu_rd_data),
        .lsu_misalign_o (lsu_misalign),
        .lsu_timeout_o  (lsu_timeout),
        .mem            (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected outputs for the current cycle, written by the stimulus.
    logic        check_en = 1'b0;
    logic        exp_stall, exp_valid, exp_mis, exp_to, exp_req, exp_wr;
    logic        chk_bus, chk_data;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("stall", {31'd0, lsu_stall}, {31'd0, exp_stall});
            chk("rd_valid", {31'd0, lsu_rd_valid}, {31'd0, exp_valid});
            chk("misalign", {31'd0, lsu_misalign}, {31'd0, exp_mis});
            chk("timeout", {31'd0, lsu_timeout}, {31'd0, exp_to});
            chk("mem_req", {31'd0, bus.mem_req_o}, {31'd0, exp_req});
            if (chk_bus) begin
                chk("mem_addr", bus.mem_addr_o, exp_addr);
                chk("mem_be", {28'd0, bus.mem_be_o}, {28'd0, exp_be});
                chk("mem_wr", {31'd0, bus.mem_wr_o}, {31'd0, exp_wr});
                chk("mem_wdata", bus.mem_wdata_o, exp_wdata);
            end
            if (chk_data) chk("rd_data", lsu_rd_data, exp_rdata);
        end
    end

    // Reference rules
    function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] a);
        int unsigned ai = a;
        if (sz == 2'd2) return 1'b1;
        if (sz == 2'd1) return (ai % 2) != 0;
        if (sz == 2'd3) return ai != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        int unsigned ai = a;
        case (sz)
            2'd0:    return 4'(1 << ai);
            2'd1:    return 4'(3 << ai);
            2'd3:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        int unsigned w = wd;
        case (sz)
            2'd0:    return (w % 256) * 32'h0101_0101;
            2'd1:    return (w % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] sz, input logic zx);
        int unsigned s = rd;
        int unsigned ai = a;
        int unsigned v;
        s = s / (1 << (8 * ai));
        case (sz)
            2'd0: begin v = s % 256;   if (!zx && v >= 128)   v = v + 32'hFFFF_FF00; end
            2'd1: begin v = s % 65536; if (!zx && v >= 32768) v = v + 32'hFFFF_0000; end
            2'd3: v = s;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0; exp_to = 1'b0;
        exp_req = 1'b0; exp_wr = 1'b0; chk_bus = 1'b0; chk_data = 1'b0;
        exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic stray);
        for (int c = 0; c < n; c++) begin
            data_req = 1'b0;
            data_addr = $urandom;
            bus.mem_gnt_i = 1'b0;
            bus.mem_rvalid_i = stray;
            bus.mem_rdata_i = $urandom;
            set_idle_exp();
            tick();
        end
        bus.mem_rvalid_i = 1'b0;
    endtask

    // One memory op. g = grant delay in REQ cycles, r = rvalid delay in WAIT
    // cycles; -1 means the bus never answers.
    task automatic do_op(input logic wr, input logic [1:0] sz, input logic zx,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic emis,
                         input int g, input int r, input logic [31:0] rdata,
                         input logic [31:0] erd);
        int k = 0, i = 0, w = 0;
        bit granted = 0, done = 0, tmo = 0;
        data_req = 1'b1; data_wr = wr; data_byte = sz; zero_extnd = zx;
        data_addr = addr; data_wdata = wd;
        bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = ($urandom_range(0, 3) == 0);
        bus.mem_rdata_i = $urandom;
        set_idle_exp();
        exp_stall = 1'b1;
        tick();
        // Scramble the request inputs: the op must run on what was captured.
        data_req = 1'b0; data_wr = 1'(~wr); data_byte = 2'($urandom);
        zero_extnd = 1'($urandom); data_addr = $urandom; data_wdata = $urandom;
        if (!emis) begin
            while (!done) begin
                k++;
                set_idle_exp();
                exp_stall = 1'b1;
                if (!granted) begin
                    exp_req = 1'b1; chk_bus = 1'b1;
                    exp_addr = addr & 32'hFFFF_FFFC; exp_be = ebe; exp_wr = wr; exp_wdata = ewd;
                    bus.mem_gnt_i = (i == g);
                    bus.mem_rvalid_i = (i != g) && ($urandom_range(0, 3) == 0);
                    bus.mem_rdata_i = $urandom;
                    if (k == TMO) begin done = 1; tmo = 1; end
                    else if (i == g) granted = 1;
                    i++;
                end else begin
                    bus.mem_gnt_i = 1'b0;
                    bus.mem_rvalid_i = (w == r);
                    bus.mem_rdata_i = (w == r) ? rdata : $urandom;
                    if (w == r) done = 1;
                    else if (k == TMO) begin done = 1; tmo = 1; end
                    w++;
                end
                tick();
            end
        end
        bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = 1'($urandom);
        bus.mem_rdata_i = $urandom;
        set_idle_exp();
        exp_valid = 1'b1; exp_mis = emis; exp_to = tmo; chk_data = 1'b1;
        exp_rdata = (tmo || emis) ? 32'h0 : erd;
        tick();
        bus.mem_rvalid_i = 1'b0;
    endtask

    task automatic rnd_op();
        logic        wr = 1'($urandom);
        logic [1:0]  sz = 2'($urandom);
        logic        zx = 1'($urandom);
        logic [31:0] a = $urandom;
        logic [31:0] wd = $urandom;
        logic [31:0] rd = $urandom;
        int g = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
        int r = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
        do_op(wr, sz, zx, a, wd, m_be(sz, a[1:0]), m_wd(sz, wd), m_mis(sz, a[1:0]),
              g, r, rd, wr ? 32'h0 : m_load(rd, a[1:0], sz, zx));
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
        set_idle_exp();
        #1 reset = 1'b1;
        #2;
        chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
        chk("rst_valid", {31'd0, lsu_rd_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_rdata", lsu_rd_data, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        check_en = 1'b1;
        idle(2, 1'b0);

        // LW 0x100: 3 stall cycles, valid on the 4th
        do_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 4'b1111, 32'h0, 1'b0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        // LB / LBU 0x103, LH 0x102
        do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 4'b1000, 32'h0, 1'b0, 0, 0, 32'h80112233, 32'hFFFFFF80);
        do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 4'b1000, 32'h0, 1'b0, 0, 1, 32'h80112233, 32'h00000080);
        do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 4'b1100, 32'h0, 1'b0, 1, 0, 32'h80015555, 32'hFFFF8001);
        // SH 0x102
        do_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 1'b0, 0, 1, 32'h0, 32'h0);
        // Misaligned / illegal size
        do_op(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        do_op(1'b1, 2'b01, 1'b0, 32'h103, 32'h5555, 4'b0000, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
        // Grant held off 3 cycles
        do_op(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 4'b1111, 32'h0, 1'b0, 3, 2, 32'h0BADF00D, 32'h0BADF00D);
        // No grant: timeout, then late rvalid ignored
        do_op(1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 4'b1111, 32'h0, 1'b0, -1, 0, 32'h0, 32'h0);
        idle(2, 1'b1);
        // Granted but no response: timeout in WAIT
        do_op(1'b1, 2'b00, 1'b0, 32'h10A, 32'h000000A5, 4'b0100, 32'hA5A5A5A5, 1'b0, 2, -1, 32'h0, 32'h0);
        idle(2, 1'b1);

        // Reset while waiting for a response
        data_req = 1'b1; data_wr = 1'b0; data_byte = 2'b11; zero_extnd = 1'b0;
        data_addr = 32'h200; set_idle_exp(); exp_stall = 1'b1;
        tick();
        data_req = 1'b0; bus.mem_gnt_i = 1'b1;
        set_idle_exp(); exp_stall = 1'b1; exp_req = 1'b1; chk_bus = 1'b1;
        exp_addr = 32'h200; exp_be = 4'hF; exp_wr = 1'b0; exp_wdata = data_wdata;
        tick();
        bus.mem_gnt_i = 1'b0;
        set_idle_exp(); exp_stall = 1'b1;
        #2;
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, lsu_stall}, 32'd0);
        chk("midrst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("midrst_valid", {31'd0, lsu_rd_valid}, 32'd0);
        chk("midrst_be", {28'd0, bus.mem_be_o}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        check_en = 1'b1;
        idle(2, 1'b1);
        do_op(1'b0, 2'b11, 1'b0, 32'h204, 32'h0, 4'b1111, 32'h0, 1'b0, 0, 0, 32'h13579BDF, 32'h13579BDF);

        // Randomized ops against the reference rules
        for (int n = 0; n < 150; n++) begin
            rnd_op();
            idle(int'($urandom_range(0, 2)), 1'($urandom));
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
